// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses a framed serial boot image and writes it to memory.
// Optional inter-byte timeout enabled by defining UARTBOOT_TIMEOUT_EN.
module uart_boot_loader #(
  parameter int FIFO_AW        = 4,
  parameter int TIMEOUT_CYCLES = 6250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rxnew,
  input  logic [7:0]  rxdata,
  output logic        mem_req,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        go,
  output logic [31:0] boot_addr,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    IDLE, SYNC0, SYNC1, ADDR, LEN,
    DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t state;

  logic [7:0]       fifo [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             empty;
  logic             full;
  logic             armed;
  logic             consume;
  logic             pop;
  logic             push;
  logic             ovf;
  logic             tmo_hit;
  logic [7:0]       head;

  logic [31:0] addr;
  logic [31:0] start;
  logic [31:0] word;
  logic [15:0] cnt;
  logic [1:0]  bcnt;
  logic [7:0]  csum;

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign head  = fifo[rptr[FIFO_AW-1:0]];

  // the fifo only collects bytes once the loader has left IDLE
  assign armed   = enable && (state != IDLE);
  assign consume = state inside {SYNC0, SYNC1, ADDR, LEN,
                                 DATA, CSUM, DONE, ERR};
  assign pop  = armed && consume && !empty;
  assign push = armed && rxnew && (!full || pop);
  assign ovf  = armed && rxnew && full && !pop;

  assign mem_a  = addr;
  assign mem_d  = word;
  assign mem_we = mem_req;
  assign busy   = !(state inside {IDLE, SYNC0, DONE, ERR});

  // byte storage, written at the tail
  always_ff @(posedge clk) begin
    if (push) fifo[wptr[FIFO_AW-1:0]] <= rxdata;
  end

  // fifo pointers, flushed while idle or disarmed
  always_ff @(posedge clk) begin
    if (rst || !armed) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

`ifdef UARTBOOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo;
  logic          timed;

  assign timed   = state inside {ADDR, LEN, DATA, CSUM};
  assign tmo_hit = timed && empty && (tmo == '0);

  // inter-byte timer: reloads on each dequeue and outside timed states
  always_ff @(posedge clk) begin
    if (rst || !timed || pop) tmo <= TMO_LOAD;
    else if (empty && tmo != '0) tmo <= tmo - 1'b1;
  end
`else
  // without the timer the loader waits forever; this never fires
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // frame parser, bus write master and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      start     <= '0;
      word      <= '0;
      cnt       <= '0;
      bcnt      <= '0;
      csum      <= '0;
      mem_req   <= 1'b0;
      done      <= 1'b0;
      go        <= 1'b0;
      boot_addr <= '0;
      err_code  <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      go      <= 1'b0;
    end else begin
      go <= 1'b0;
      if (ovf) begin
        err_code <= 2'd2;
        mem_req  <= 1'b0;
        state    <= ERR;
      end else if (tmo_hit) begin
        err_code <= 2'd3;
        state    <= ERR;
      end else begin
        unique case (state)
          IDLE: begin
            done     <= 1'b0;
            err_code <= '0;
            state    <= SYNC0;
          end
          SYNC0: begin
            if (pop && head == 8'hA5) state <= SYNC1;
          end
          SYNC1: begin
            if (pop) begin
              if (head == 8'h5A) begin
                csum  <= '0;
                bcnt  <= '0;
                state <= ADDR;
              end else if (head != 8'hA5) begin
                state <= SYNC0;
              end
            end
          end
          ADDR: begin
            if (pop) begin
              csum <= csum + head;
              bcnt <= bcnt + 1'b1;
              if (bcnt == 2'd3) begin
                addr  <= {addr[23:0], head[7:2], 2'b00};
                start <= {addr[23:0], head[7:2], 2'b00};
                state <= LEN;
              end else begin
                addr <= {addr[23:0], head};
              end
            end
          end
          LEN: begin
            if (pop) begin
              csum <= csum + head;
              cnt  <= {cnt[7:0], head};
              if (bcnt == 2'd1) begin
                bcnt  <= '0;
                state <= ({cnt[7:0], head} == 16'd0) ? CSUM : DATA;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (pop) begin
              csum <= csum + head;
              word <= {word[23:0], head};
              bcnt <= bcnt + 1'b1;
              if (bcnt == 2'd3) begin
                mem_req <= 1'b1;
                state   <= WRITE;
              end
            end
          end
          WRITE: begin
            if (mem_ready) begin
              mem_req <= 1'b0;
              addr    <= addr + 32'd4;
              cnt     <= cnt - 16'd1;
              state   <= (cnt == 16'd1) ? CSUM : DATA;
            end
          end
          CSUM: begin
            if (pop) begin
              if (head == csum) begin
                done      <= 1'b1;
                go        <= 1'b1;
                boot_addr <= start;
                state     <= DONE;
              end else begin
                err_code <= 2'd1;
                state    <= ERR;
              end
            end
          end
          DONE, ERR: begin
            state <= state;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed and randomized frames against a
// field-level model of the boot image (writes, checksum, status).
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rxnew;
  logic [7:0]  rxdata;
  logic        mem_req;
  logic [31:0] mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        go;
  logic [31:0] boot_addr;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  logic [63:0] wr_q[$];
  int          go_cnt = 0;
  bit          rdy_rand = 1'b0;
  logic        rdy_force = 1'b0;
  int          stall_run = 0;
  logic [31:0] last_boot = '0;

  logic [7:0]  frame_q[$];
  logic [31:0] words[$];

  uart_boot_loader dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rxnew     (rxnew),
    .rxdata    (rxdata),
    .mem_req   (mem_req),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .go        (go),
    .boot_addr (boot_addr),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // bus ready: forced level, or random with stalls capped at 3 cycles
  always @(posedge clk) begin
    #2;
    if (rdy_rand) begin
      if (stall_run >= 3) begin
        mem_ready = 1'b1;
        stall_run = 0;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        stall_run = mem_ready ? 0 : stall_run + 1;
      end
    end else begin
      mem_ready = rdy_force;
    end
  end

  // record accepted writes and go pulses mid-cycle
  always @(negedge clk) begin
    if (mem_req && mem_ready) wr_q.push_back({mem_a, mem_d});
    if (go) go_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rxnew  = 1'b1;
    rxdata = b;
    tick();
    rxnew  = 1'b0;
  endtask

  task automatic send_frame(input int gmin, input int gmax);
    foreach (frame_q[i]) begin
      send(frame_q[i]);
      tick($urandom_range(gmin, gmax));
    end
  endtask

  task automatic rearm();
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
    wr_q.delete();
    go_cnt = 0;
  endtask

  task automatic wait_end(input int lim);
    int k = 0;
    while (!(done || err_code != 2'd0) && k < lim) begin
      tick();
      k++;
    end
    check("wait_end", k < lim, 1);
  endtask

  task automatic wait_req(input int lim);
    int k = 0;
    while (!mem_req && k < lim) begin
      tick();
      k++;
    end
    check("wait_req", k < lim, 1);
  endtask

  function automatic logic [63:0] wr_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : '1;
  endfunction

  // frame from fields: sync, address, count, words, mod-256 checksum
  task automatic build(input logic [31:0] a, input bit bad);
    logic [47:0] hdr;
    int acc;
    hdr = {a, 16'(words.size())};
    frame_q = {8'hA5, 8'h5A};
    for (int i = 0; i < 6; i++) frame_q.push_back(hdr[47-8*i -: 8]);
    foreach (words[w])
      for (int i = 0; i < 4; i++) frame_q.push_back(words[w][31-8*i -: 8]);
    acc = 0;
    for (int i = 2; i < frame_q.size(); i++) acc += int'(frame_q[i]);
    if (bad) acc += int'($urandom_range(1, 255));
    frame_q.push_back(8'(acc));
  endtask

  task automatic spec_frame(input logic [7:0] last);
    frame_q = {8'hA5, 8'h5A, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
               8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, last};
  endtask

  task automatic run_random(input int id);
    logic [31:0] a;
    logic [31:0] ea;
    int n;
    bit bad;
    a = $urandom;
    n = $urandom_range(0, 3);
    if (id == 0) begin
      a = 32'hFFFF_FFF9;
      n = 3;
    end
    words.delete();
    repeat (n) words.push_back($urandom);
    bad = ($urandom_range(0, 3) == 0);
    build(a, bad);
    rearm();
    rdy_rand = 1'b1;
    repeat ($urandom_range(0, 3)) send(8'($urandom_range(0, 164)));
    send_frame(1, 3);
    wait_end(2000);
    tick(3);
    check("rnd_nwr", wr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      ea = {a[31:2], 2'b00} + 32'(4 * i);
      check("rnd_wr", wr_at(i), {ea, words[i]});
    end
    if (!bad) last_boot = {a[31:2], 2'b00};
    check("rnd_done", done, !bad);
    check("rnd_err", err_code, bad ? 2'd1 : 2'd0);
    check("rnd_go", go_cnt, bad ? 0 : 1);
    check("rnd_boot", boot_addr, last_boot);
    check("rnd_busy", busy, 0);
    rdy_rand = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    rxnew = 1'b0;
    rxdata = '0;
    rdy_force = 1'b1;
    tick(3);
    check("rst_flags", {mem_req, mem_we, busy, done, go, err_code}, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_d", mem_d, 0);
    check("rst_boot", boot_addr, 0);
    rst = 1'b0;
    tick();

    // good frame, bus always ready
    spec_frame(8'h49);
    rearm();
    send_frame(0, 0);
    wait_end(200);
    tick(3);
    check("a_nwr", wr_q.size(), 1);
    check("a_wr", wr_at(0), {32'h0000_1000, 32'hDEAD_BEEF});
    check("a_go", go_cnt, 1);
    check("a_done", done, 1);
    check("a_boot", boot_addr, 32'h0000_1000);
    check("a_err", err_code, 0);
    last_boot = 32'h0000_1000;

    // bus stalls 5 cycles; request must hold steady
    rdy_force = 1'b0;
    rearm();
    send_frame(0, 0);
    wait_req(200);
    for (int k = 0; k < 5; k++) begin
      check("b_req", {mem_req, mem_we}, 2'b11);
      check("b_a", mem_a, 32'h0000_1000);
      check("b_d", mem_d, 32'hDEAD_BEEF);
      tick();
    end
    rdy_force = 1'b1;
    wait_end(200);
    tick(3);
    check("b_nwr", wr_q.size(), 1);
    check("b_done", done, 1);
    check("b_go", go_cnt, 1);

    // bad checksum
    spec_frame(8'h48);
    rearm();
    send_frame(0, 0);
    wait_end(200);
    tick(3);
    check("c_nwr", wr_q.size(), 1);
    check("c_err", err_code, 1);
    check("c_done", done, 0);
    check("c_go", go_cnt, 0);
    check("c_boot", boot_addr, last_boot);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick(2);
    check("c_rearm_err", err_code, 0);

    // garbage, repeated A5, zero-length frame at address 0
    frame_q = {8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00};
    rearm();
    send_frame(0, 0);
    wait_end(200);
    tick(3);
    check("d_nwr", wr_q.size(), 0);
    check("d_done", done, 1);
    check("d_boot", boot_addr, 0);
    check("d_go", go_cnt, 1);
    check("d_err", err_code, 0);
    last_boot = '0;

    // fifo overflow while a write stalls
    rdy_force = 1'b0;
    words = {32'h1122_3344, 32'h5566_7788};
    build(32'h0000_2000, 1'b0);
    repeat (17) frame_q.push_back(8'h00);
    rearm();
    send_frame(0, 0);
    wait_end(200);
    tick(2);
    check("e_err", err_code, 2);
    check("e_req", mem_req, 0);
    check("e_busy", busy, 0);
    rdy_force = 1'b1;
    tick(3);
    check("e_nwr", wr_q.size(), 0);
    check("e_done", done, 0);

    // stalled header: no timeout in this build
    frame_q = {8'hA5, 8'h5A, 8'h00, 8'h00};
    rearm();
    send_frame(0, 0);
    tick(200);
    check("f_busy", busy, 1);
    check("f_err", err_code, 0);

    // enable drop abandons a pending write
    rdy_force = 1'b0;
    spec_frame(8'h49);
    rearm();
    send_frame(0, 0);
    wait_req(200);
    enable = 1'b0;
    tick();
    check("g_req", mem_req, 0);
    check("g_busy", busy, 0);
    rdy_force = 1'b1;
    tick(3);
    check("g_nwr", wr_q.size(), 0);

    // reset mid-write
    rdy_force = 1'b0;
    rearm();
    send_frame(0, 0);
    wait_req(200);
    rst = 1'b1;
    tick();
    check("h_req", mem_req, 0);
    check("h_flags", {busy, done, err_code}, 0);
    check("h_boot", boot_addr, 0);
    last_boot = '0;
    rst = 1'b0;
    rdy_force = 1'b1;
    tick(3);
    check("h_nwr", wr_q.size(), 0);

    for (int i = 0; i < 10; i++) run_random(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
